// File: rtl/rect_pkg.sv
// rtl/rect_pkg.sv - shared constants, state encoding and lookup helpers for rect_finder
package rect_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int NCAND = 36;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] lo;
        logic [1:0] hi;
    } pair_t;

    // Column-major packing with (0,0) in the MSB, matching the flip block.
    function automatic logic [3:0] bit_index(input logic [1:0] r, input logic [1:0] c);
        return 4'(15 - (int'(c) * ROWS + int'(r)));
    endfunction

    function automatic pair_t pair_of(input logic [2:0] p);
        pair_t pr;
        case (p)
            3'd0:    pr = '{lo: 2'd0, hi: 2'd1};
            3'd1:    pr = '{lo: 2'd0, hi: 2'd2};
            3'd2:    pr = '{lo: 2'd0, hi: 2'd3};
            3'd3:    pr = '{lo: 2'd1, hi: 2'd2};
            3'd4:    pr = '{lo: 2'd1, hi: 2'd3};
            3'd5:    pr = '{lo: 2'd2, hi: 2'd3};
            default: pr = '{lo: 2'd0, hi: 2'd0};
        endcase
        return pr;
    endfunction

endpackage

// File: rtl/rect_cand_rom.sv
// rtl/rect_cand_rom.sv - maps candidate index (row pair * 6 + column pair) to rectangle corners
module rect_cand_rom
    import rect_pkg::*;
(
    input  logic [5:0] idx,
    output logic [1:0] r1,
    output logic [1:0] r2,
    output logic [1:0] c1,
    output logic [1:0] c2
);

    logic [2:0] rp;
    logic [2:0] cp;
    pair_t      rpair;
    pair_t      cpair;

    always_comb begin
        rp    = 3'(idx / 6'd6);
        cp    = 3'(idx % 6'd6);
        rpair = pair_of(rp);
        cpair = pair_of(cp);
        r1    = rpair.lo;
        r2    = rpair.hi;
        c1    = cpair.lo;
        c2    = cpair.hi;
    end

endmodule

// File: rtl/rect_finder.sv
// rtl/rect_finder.sv - scans a 4x4 binary matrix and streams every sum-preserving flip rectangle
module rect_finder
    import rect_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [15:0] m_in,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [1:0]  o_r1,
    output logic [1:0]  o_r2,
    output logic [1:0]  o_c1,
    output logic [1:0]  o_c2,
    output logic        o_done,
    output logic [5:0]  o_count
);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  count_q, count_d;
    logic [15:0] mat_q, mat_d;
    logic [1:0]  r1_q, r1_d, r2_q, r2_d, c1_q, c1_d, c2_q, c2_d;

    logic [1:0]  cand_r1, cand_r2, cand_c1, cand_c2;
    logic        a_bit, b_bit, d_bit, e_bit;
    logic        match;
    logic        last;

    rect_cand_rom u_rom (
        .idx (idx_q),
        .r1  (cand_r1),
        .r2  (cand_r2),
        .c1  (cand_c1),
        .c2  (cand_c2)
    );

    // Alternating corners: diagonal pair equal, anti-diagonal pair equal, and the two differ.
    always_comb begin
        a_bit = mat_q[bit_index(cand_r1, cand_c1)];
        d_bit = mat_q[bit_index(cand_r2, cand_c2)];
        b_bit = mat_q[bit_index(cand_r1, cand_c2)];
        e_bit = mat_q[bit_index(cand_r2, cand_c1)];
        match = (a_bit == d_bit) && (b_bit == e_bit) && (a_bit != b_bit);
        last  = (idx_q == 6'(NCAND - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        mat_d   = mat_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    mat_d   = m_in;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (match) begin
                    r1_d    = cand_r1;
                    r2_d    = cand_r2;
                    c1_d    = cand_c1;
                    c2_d    = cand_c2;
                    count_d = count_q + 6'd1;
                    state_d = ST_EMIT;
                end else if (last) begin
                    {r1_d, r2_d, c1_d, c2_d} = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_EMIT: begin
                if (o_ready) begin
                    if (last) begin
                        {r1_d, r2_d, c1_d, c2_d} = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                if (o_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            mat_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            mat_q   <= mat_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
        end
    end

    // Handshake outputs are decoded straight from the state register so they stay glitch-free.
    assign m_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_EMIT) || (state_q == ST_DONE);
    assign o_done  = (state_q == ST_DONE);
    assign o_r1    = r1_q;
    assign o_r2    = r2_q;
    assign o_c1    = c1_q;
    assign o_c2    = c2_q;
    assign o_count = count_q;

endmodule
